// File: rtl/fir_mac_scheduler.sv
// Multi-channel decimating FIR: per-channel circular delay lines share one
// symmetric pre-add MAC, sequenced by a small IDLE/MAC/ROUND/OUT FSM.

module fir_dline #(
  parameter int NTAP   = 35,
  parameter int DATA_W = 18,
  parameter int TW     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TW-1:0]     ia,
  input  logic [TW-1:0]     ib,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb,
  output logic [TW-1:0]     wp
);
  localparam logic [TW-1:0] TLAST = TW'(NTAP-1);

  logic [NTAP-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wp  <= '0;
    end else if (we) begin
      mem[wp] <= wdata;
      wp      <= (wp == TLAST) ? '0 : wp + TW'(1);
    end
  end

  assign ra = mem[ia];
  assign rb = mem[ib];
endmodule

module fir_mac_scheduler #(
  parameter int NCH    = 4,
  parameter int NTAP   = 35,
  parameter int DATA_W = 18,
  parameter int COEF_W = 25,
  parameter int ACC_W  = 48,
  parameter int DEC    = 2,
  parameter int SHIFT  = 18,
  parameter int OUT_W  = 16,
  localparam int H     = (NTAP + 1) / 2,
  localparam int AW    = (H > 1) ? $clog2(H) : 1,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic [CW-1:0]            m_chan,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  output logic                     cfg_err
);
  localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int TW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int PRW = COEF_W + DATA_W + 1;
  localparam logic [TW-1:0] TLAST = TW'(NTAP-1);
  localparam logic [AW:0]   HV    = (AW+1)'(H);
  localparam logic [AW-1:0] KLAST = AW'(H-1);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;
  state_t state, nstate;

  logic [CW-1:0]  ch;
  logic [PW-1:0]  phase;
  logic [AW-1:0]  k;
  logic [TW-1:0]  ia, ib;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef [H];

  logic accept, comp, last_ch, adv, cfg_ok, cfg_bad;
  logic [NCH-1:0] lane_we;
  logic [NCH-1:0][DATA_W-1:0] ra, rb;
  logic [NCH-1:0][TW-1:0]     wp;

  // One delay line per channel; only the channel whose turn it is gets written.
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign lane_we[g] = accept && (ch == CW'(g));
    fir_dline #(.NTAP(NTAP), .DATA_W(DATA_W), .TW(TW)) u_dline (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[g]),
      .wdata (s_data),
      .ia    (ia),
      .ib    (ib),
      .ra    (ra[g]),
      .rb    (rb[g]),
      .wp    (wp[g])
    );
  end

  // Symmetric pre-add; the centre tap has no mirror partner.
  logic [DATA_W-1:0]        xa, xb;
  logic signed [DATA_W:0]   pre;
  logic signed [PRW-1:0]    prod;
  logic signed [ACC_W-1:0]  sh;
  logic signed [OUT_W-1:0]  sat;

  always_comb begin
    xa   = ra[ch];
    xb   = (k == KLAST) ? '0 : rb[ch];
    pre  = {xa[DATA_W-1], xa} + {xb[DATA_W-1], xb};
    prod = coef[k] * pre;
    sh   = acc >>> SHIFT;
    if (sh > OMAX)      sat = OMAX[OUT_W-1:0];
    else if (sh < OMIN) sat = OMIN[OUT_W-1:0];
    else                sat = sh[OUT_W-1:0];
  end

  always_comb begin
    nstate  = state;
    s_ready = (state == S_IDLE);
    m_valid = (state == S_OUT);
    accept  = s_valid && s_ready;
    comp    = (phase == PW'(DEC-1));
    last_ch = (ch == CW'(NCH-1));
    adv     = (accept && !comp) || (m_valid && m_ready);
    cfg_ok  = cfg_we && (state == S_IDLE) && ({1'b0, cfg_addr} < HV);
    cfg_bad = cfg_we && !cfg_ok;
    case (state)
      S_IDLE:  if (accept && comp) nstate = S_MAC;
      S_MAC:   if (k == KLAST)     nstate = S_ROUND;
      S_ROUND:                     nstate = S_OUT;
      S_OUT:   if (m_ready)        nstate = S_IDLE;
      default:                     nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) coef[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_ok)  coef[cfg_addr] <= cfg_data;
      if (cfg_bad) cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch     <= '0;
      phase  <= '0;
      k      <= '0;
      ia     <= '0;
      ib     <= '0;
      acc    <= '0;
      m_data <= '0;
      m_chan <= '0;
    end else begin
      if (adv) begin
        ch <= last_ch ? '0 : ch + CW'(1);
        if (last_ch) phase <= comp ? '0 : phase + PW'(1);
      end
      case (state)
        S_IDLE: if (accept && comp) begin
          // x[n] sits at the write slot; its mirror x[n-(NTAP-1)] is the next slot.
          acc <= '0;
          k   <= '0;
          ia  <= wp[ch];
          ib  <= (wp[ch] == TLAST) ? '0 : wp[ch] + TW'(1);
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + AW'(1);
          ia  <= (ia == '0) ? TLAST : ia - TW'(1);
          ib  <= (ib == TLAST) ? '0 : ib + TW'(1);
        end
        S_ROUND: begin
          m_data <= sat;
          m_chan <= ch;
        end
        default: ;
      endcase
    end
  end
endmodule
